// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM: round-robin with a bounded
// burst lock, registered BRAM drive, and read data routed back through a tagged pipe.
module bram_port_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              a_req_i,
  input  logic [DW/8-1:0]   a_we_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [DW-1:0]     a_wdata_i,
  output logic              a_ack_o,
  output logic              a_rvalid_o,
  output logic [DW-1:0]     a_rdata_o,

  input  logic              b_req_i,
  input  logic [DW/8-1:0]   b_we_i,
  input  logic [AW-1:0]     b_addr_i,
  input  logic [DW-1:0]     b_wdata_i,
  output logic              b_ack_o,
  output logic              b_rvalid_o,
  output logic [DW-1:0]     b_rdata_o,

  output logic              bram_en_o,
  output logic [DW/8-1:0]   bram_we_o,
  output logic [AW-1:0]     bram_addr_o,
  output logic [DW-1:0]     bram_din_o,
  input  logic [DW-1:0]     bram_dout_i,

  output logic [1:0]        owner_o
);

  localparam int BW = DW / 8;
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              lastB_q, lastB_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              grantA, grantB;
  logic              isRead;

  logic              bramEn_q;
  logic [BW-1:0]     bramWe_q;
  logic [AW-1:0]     bramAddr_q;
  logic [DW-1:0]     bramDin_q;

  logic [RD_LAT:0]   pipeV_q;
  logic [RD_LAT:0]   pipeP_q;
  logic [DW-1:0]     aRdata_q, bRdata_q;
  logic              aHit, bHit;

  // Grant is decided from the current owner, both requests and the burst count;
  // no accept is ever issued while reset is asserted.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (a_req_i && b_req_i) begin
            grantA = lastB_q;
            grantB = !lastB_q;
          end else begin
            grantA = a_req_i;
            grantB = b_req_i;
          end
        end
        OWN_A: begin
          if (a_req_i) begin
            if (b_req_i && (cnt_q >= MAX_CNT)) grantB = 1'b1;
            else                               grantA = 1'b1;
          end else begin
            grantB = b_req_i;
          end
        end
        OWN_B: begin
          if (b_req_i) begin
            if (a_req_i && (cnt_q >= MAX_CNT)) grantA = 1'b1;
            else                               grantB = 1'b1;
          end else begin
            grantA = a_req_i;
          end
        end
        default: begin
          grantA = 1'b0;
          grantB = 1'b0;
        end
      endcase
    end
  end

  // Staying with the same owner counts up (saturating); a new owner restarts at 1.
  always_comb begin
    state_d = IDLE;
    lastB_d = lastB_q;
    cnt_d   = cnt_q;
    if (grantA) begin
      state_d = OWN_A;
      if (state_q == OWN_A) begin
        cnt_d = (cnt_q >= MAX_CNT) ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_d   = 8'd1;
        lastB_d = 1'b0;
      end
    end else if (grantB) begin
      state_d = OWN_B;
      if (state_q == OWN_B) begin
        cnt_d = (cnt_q >= MAX_CNT) ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_d   = 8'd1;
        lastB_d = 1'b1;
      end
    end
  end

  assign isRead = (grantA && (a_we_i == '0)) || (grantB && (b_we_i == '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lastB_q    <= 1'b1;
      cnt_q      <= 8'd0;
      bramEn_q   <= 1'b0;
      bramWe_q   <= '0;
      bramAddr_q <= '0;
      bramDin_q  <= '0;
      pipeV_q    <= '0;
      pipeP_q    <= '0;
      aRdata_q   <= '0;
      bRdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      lastB_q  <= lastB_d;
      cnt_q    <= cnt_d;
      bramEn_q <= grantA || grantB;
      if (grantA) begin
        bramWe_q   <= a_we_i;
        bramAddr_q <= a_addr_i;
        bramDin_q  <= a_wdata_i;
      end else if (grantB) begin
        bramWe_q   <= b_we_i;
        bramAddr_q <= b_addr_i;
        bramDin_q  <= b_wdata_i;
      end else begin
        bramWe_q   <= '0;
      end
      // Stage k of the tag pipe lines up with cycle t+1+k of an accept at t.
      if (RD_LAT > 0) begin
        pipeV_q <= {pipeV_q[RD_LAT-1:0], isRead};
        pipeP_q <= {pipeP_q[RD_LAT-1:0], grantB};
      end
      if (aHit) aRdata_q <= bram_dout_i;
      if (bHit) bRdata_q <= bram_dout_i;
    end
  end

  assign aHit = pipeV_q[RD_LAT] && !pipeP_q[RD_LAT];
  assign bHit = pipeV_q[RD_LAT] &&  pipeP_q[RD_LAT];

  assign a_ack_o     = grantA;
  assign b_ack_o     = grantB;
  assign a_rvalid_o  = aHit;
  assign b_rvalid_o  = bHit;
  assign a_rdata_o   = aHit ? bram_dout_i : aRdata_q;
  assign b_rdata_o   = bHit ? bram_dout_i : bRdata_q;

  assign bram_en_o   = bramEn_q;
  assign bram_we_o   = bramWe_q;
  assign bram_addr_o = bramAddr_q;
  assign bram_din_o  = bramDin_q;
  assign owner_o     = state_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a one-cycle-latency BRAM model attached.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        aReq, bReq;
  logic [3:0]  aWe, bWe;
  logic [13:0] aAddr, bAddr;
  logic [31:0] aWdata, bWdata;
  logic        aAck, bAck, aRvalid, bRvalid;
  logic [31:0] aRdata, bRdata;
  logic        bramEn;
  logic [3:0]  bramWe;
  logic [13:0] bramAddr;
  logic [31:0] bramDin, bramDout;
  logic [1:0]  owner;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:16383];

  bram_port_arbiter #(.AW(14), .DW(32), .RD_LAT(1), .MAX_BURST(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(aReq), .a_we_i(aWe), .a_addr_i(aAddr), .a_wdata_i(aWdata),
    .a_ack_o(aAck), .a_rvalid_o(aRvalid), .a_rdata_o(aRdata),
    .b_req_i(bReq), .b_we_i(bWe), .b_addr_i(bAddr), .b_wdata_i(bWdata),
    .b_ack_o(bAck), .b_rvalid_o(bRvalid), .b_rdata_o(bRdata),
    .bram_en_o(bramEn), .bram_we_o(bramWe), .bram_addr_o(bramAddr),
    .bram_din_o(bramDin), .bram_dout_i(bramDout),
    .owner_o(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port BRAM with byte enables and one cycle of read latency.
  always @(posedge clk) begin
    if (bramEn) begin
      for (int i = 0; i < 4; i++)
        if (bramWe[i]) mem[bramAddr][i*8 +: 8] <= bramDin[i*8 +: 8];
      bramDout <= mem[bramAddr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task nextCycle();
    @(posedge clk);
    #1;
  endtask

  task idleInputs();
    aReq = 0; bReq = 0; aWe = 0; bWe = 0;
    aAddr = 0; bAddr = 0; aWdata = 0; bWdata = 0;
  endtask

  task resetDut();
    idleInputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task test_reset();
    idleInputs();
    rst = 1;
    #1;
    total++;
    if ({bramEn, bramWe, owner, aAck, bAck, aRvalid, bRvalid} !== 11'd0) begin
      bad++; $display("[TB] FAIL reset_ctrl: got %b want 0", {bramEn, bramWe, owner, aAck, bAck, aRvalid, bRvalid});
    end
    total++;
    if ({bramAddr, bramDin, aRdata, bRdata} !== '0) begin
      bad++; $display("[TB] FAIL reset_data: got %h want 0", {bramAddr, bramDin, aRdata, bRdata});
    end
    mem[14'h010] = 32'h12345678;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      aReq = 1; aWe = 4'h0; aAddr = 14'h010;
    end
    @(negedge clk);
    total++;
    if ({aRvalid, aRdata} !== {1'b1, 32'h12345678}) begin
      bad++; $display("[TB] FAIL reset_pre_read: got %b/%h want 1/12345678", aRvalid, aRdata);
    end
    #2 rst = 1;
    #1;
    total++;
    if ({bramEn, owner, aAck, aRvalid, bramAddr} !== '0) begin
      bad++; $display("[TB] FAIL reset_async: got en=%b own=%b ack=%b rv=%b addr=%h want all 0", bramEn, owner, aAck, aRvalid, bramAddr);
    end
    aReq = 0;
    nextCycle();
    nextCycle();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({aRvalid, bRvalid, owner} !== 4'b0) begin
        bad++; $display("[TB] FAIL reset_flush_%0d: got rv=%b%b own=%b want 0", k, aRvalid, bRvalid, owner);
      end
      nextCycle();
    end
  endtask

  task test_a_only();
    resetDut();
    nextCycle();
    aReq = 1; aWe = 4'hF; aAddr = 14'h010; aWdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({aAck, bAck} !== 2'b10) begin
      bad++; $display("[TB] FAIL aonly_wr_ack: got %b want 10", {aAck, bAck});
    end
    nextCycle();
    aWe = 4'h0;
    @(negedge clk);
    total++;
    if ({bramEn, bramWe, bramAddr, bramDin, owner} !== {1'b1, 4'hF, 14'h010, 32'hDEADBEEF, 2'b01}) begin
      bad++; $display("[TB] FAIL aonly_drive: got en=%b we=%h addr=%h din=%h own=%b want 1/f/010/deadbeef/01", bramEn, bramWe, bramAddr, bramDin, owner);
    end
    nextCycle();
    aReq = 0;
    @(negedge clk);
    total++;
    if ({bramEn, bramWe, aRvalid} !== {1'b1, 4'h0, 1'b0}) begin
      bad++; $display("[TB] FAIL aonly_rd_drive: got en=%b we=%h rv=%b want 1/0/0", bramEn, bramWe, aRvalid);
    end
    nextCycle();
    @(negedge clk);
    total++;
    if ({aRvalid, aRdata, bRvalid, bramEn, owner} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("[TB] FAIL aonly_rdata: got rv=%b d=%h brv=%b en=%b own=%b want 1/deadbeef/0/0/00", aRvalid, aRdata, bRvalid, bramEn, owner);
    end
    nextCycle();
    @(negedge clk);
    total++;
    if (aRvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL aonly_pulse: got %b want 0", aRvalid);
    end
  endtask

  task test_tie();
    logic [1:0] expAck [5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] expOwn [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    bit         aOn [5]    = '{1, 1, 0, 0, 0};
    bit         bOn [5]    = '{1, 1, 1, 0, 0};
    resetDut();
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      aReq = aOn[k]; bReq = bOn[k]; aAddr = 14'h100; bAddr = 14'h200;
      @(negedge clk);
      total++;
      if ({aAck, bAck, owner} !== {expAck[k], expOwn[k]}) begin
        bad++; $display("[TB] FAIL tie_c%0d: got ack=%b own=%b want ack=%b own=%b", k, {aAck, bAck}, owner, expAck[k], expOwn[k]);
      end
    end
  endtask

  task test_burst_lock();
    int aCnt, bCnt, aRv, bRv;
    logic [1:0] exp;
    aCnt = 0; bCnt = 0; aRv = 0; bRv = 0;
    resetDut();
    for (int k = 0; k < 56; k++) begin
      nextCycle();
      aReq = (aCnt < 40); bReq = (bCnt < 16);
      aAddr = 14'(k); bAddr = 14'(k + 100);
      @(negedge clk);
      exp = (k < 16 || k >= 32) ? 2'b10 : 2'b01;
      total++;
      if ({aAck, bAck} !== exp) begin
        bad++; $display("[TB] FAIL burst_c%0d: got %b want %b", k, {aAck, bAck}, exp);
      end
      if (aAck) aCnt++;
      if (bAck) bCnt++;
      if (aRvalid) aRv++;
      if (bRvalid) bRv++;
    end
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      aReq = 0; bReq = 0;
      @(negedge clk);
      if (aRvalid) aRv++;
      if (bRvalid) bRv++;
    end
    total++;
    if (aRv !== 40 || bRv !== 16) begin
      bad++; $display("[TB] FAIL burst_rvalids: got a=%0d b=%0d want a=40 b=16", aRv, bRv);
    end
  endtask

  task test_interleave();
    bit         aOn [6]  = '{1, 0, 1, 0, 0, 0};
    bit         bOn [6]  = '{0, 1, 0, 1, 0, 0};
    logic [1:0] expAck [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] expRv [6]  = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    mem[14'h100] = 32'h11;
    mem[14'h200] = 32'h22;
    resetDut();
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      aReq = aOn[k]; bReq = bOn[k]; aWe = 0; bWe = 0;
      aAddr = 14'h100; bAddr = 14'h200;
      @(negedge clk);
      total++;
      if ({aAck, bAck, aRvalid, bRvalid} !== {expAck[k], expRv[k]}) begin
        bad++; $display("[TB] FAIL inter_c%0d: got ack=%b rv=%b want ack=%b rv=%b", k, {aAck, bAck}, {aRvalid, bRvalid}, expAck[k], expRv[k]);
      end
      if (k >= 2) begin
        total++;
        if (aRdata !== 32'h11) begin
          bad++; $display("[TB] FAIL inter_adata_c%0d: got %h want 00000011", k, aRdata);
        end
      end
      if (k >= 3) begin
        total++;
        if (bRdata !== 32'h22) begin
          bad++; $display("[TB] FAIL inter_bdata_c%0d: got %h want 00000022", k, bRdata);
        end
      end
    end
  endtask

  task test_partial_write();
    mem[14'h300] = 32'hFFFFFFFF;
    resetDut();
    nextCycle();
    bReq = 1; bWe = 4'b0011; bAddr = 14'h300; bWdata = 32'hAAAA5555;
    @(negedge clk);
    total++;
    if ({aAck, bAck} !== 2'b01) begin
      bad++; $display("[TB] FAIL pw_ack: got %b want 01", {aAck, bAck});
    end
    nextCycle();
    bWe = 4'b0000;
    @(negedge clk);
    total++;
    if ({bramWe, bramAddr, bramDin, bAck} !== {4'b0011, 14'h300, 32'hAAAA5555, 1'b1}) begin
      bad++; $display("[TB] FAIL pw_drive: got we=%b addr=%h din=%h ack=%b want 0011/300/aaaa5555/1", bramWe, bramAddr, bramDin, bAck);
    end
    nextCycle();
    bReq = 0;
    @(negedge clk);
    total++;
    if (bRvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL pw_early: got %b want 0", bRvalid);
    end
    nextCycle();
    @(negedge clk);
    total++;
    if ({bRvalid, bRdata, aRvalid} !== {1'b1, 32'hFFFF5555, 1'b0}) begin
      bad++; $display("[TB] FAIL pw_readback: got rv=%b d=%h arv=%b want 1/ffff5555/0", bRvalid, bRdata, aRvalid);
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_tie();
    test_burst_lock();
    test_interleave();
    test_partial_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
